led_display_ctrl: RTL

LED_DISPLAY_CTRL -- requirements
Module: led_display_ctrl

---
 rtl/led_display_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/led_display_ctrl.sv
// led_display_ctrl: debounced run/mode keys drive a RUN/PAUSE/STEP counter whose
// selected bit fields are latched onto the LED and segment outputs once per video frame.
module led_display_ctrl #(
    parameter int DEBOUNCE_CYCLES = 740000,
    parameter int CNT_W           = 48
) (
    input  logic        clk_video,
    input  logic        KEY0,
    input  logic        key_run,
    input  logic        key_mode,
    input  logic        frame_start,
    output logic [15:0] red_leds,
    output logic [15:0] green_leds,
    output logic [31:0] segments,
    output logic [1:0]  state,
    output logic [1:0]  view
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {RUN = 2'd0, PAUSE = 2'd1, STEP = 2'd2} state_t;

    // bit 0 = run key, bit 1 = mode key
    logic [1:0]    sync1, sync2, acc, press;
    logic [DW-1:0] dcnt [2];
    state_t        st, st_nxt;
    logic [1:0]    view_r, view_nxt;
    logic [CNT_W-1:0] cnt;
    logic [15:0]   red_sel, green_sel;
    logic [31:0]   seg_sel;

    always_ff @(posedge clk_video or negedge KEY0) begin
        if (!KEY0) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= {key_mode, key_run};
            sync2 <= sync1;
        end
    end

    // A differing level is accepted on its DEBOUNCE_CYCLES-th consecutive sample
    always_ff @(posedge clk_video or negedge KEY0) begin
        if (!KEY0) begin
            acc   <= 2'b11;
            press <= 2'b00;
            for (int i = 0; i < 2; i++) dcnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == acc[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DLAST) begin
                    acc[i]   <= sync2[i];
                    dcnt[i]  <= '0;
                    press[i] <= ~sync2[i];
                end else begin
                    dcnt[i] <= dcnt[i] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_video or negedge KEY0) begin
        if (!KEY0) begin
            st     <= RUN;
            view_r <= 2'd0;
            cnt    <= '0;
        end else begin
            st     <= st_nxt;
            view_r <= view_nxt;
            cnt    <= (st == RUN || st == STEP) ? cnt + CNT_W'(1) : cnt;
        end
    end

    // Run press wins over a simultaneous mode press; STEP ignores both
    always_comb begin
        st_nxt   = st;
        view_nxt = view_r;
        case (st)
            RUN: begin
                if (press[0]) st_nxt = PAUSE;
                else if (press[1]) view_nxt = view_r + 2'd1;
            end
            PAUSE: st_nxt = press[0] ? RUN : (press[1] ? STEP : PAUSE);
            STEP: st_nxt = PAUSE;
            default: st_nxt = RUN;
        endcase
    end

    always_comb begin
        red_sel   = 16'hAAAA;
        green_sel = 16'h5555;
        seg_sel   = 32'h01234567;
        case (view_r)
            2'd0: begin
                red_sel   = cnt[31:16];
                green_sel = cnt[30:15];
                seg_sel   = cnt[47:16];
            end
            2'd1: begin
                red_sel   = cnt[47:32];
                green_sel = cnt[46:31];
                seg_sel   = cnt[31:0];
            end
            2'd2: begin
                red_sel   = cnt[23:8];
                green_sel = cnt[22:7];
                seg_sel   = cnt[39:8];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_video or negedge KEY0) begin
        if (!KEY0) begin
            red_leds   <= '0;
            green_leds <= '0;
            segments   <= '0;
        end else if (frame_start) begin
            red_leds   <= red_sel;
            green_leds <= green_sel;
            segments   <= seg_sel;
        end
    end

    assign state = st;
    assign view  = view_r;
endmodule
